multicycle_control: RTL

Multi-cycle control unit for the 4-bit-opcode CPU datapath. A registered Moore FSM sequences each instruction (add, sub, and, or, addi, beq, j, lw, sw) over 3–5 states. Memory access uses a ready handshake with wait states. It replaces the single-cycle combinational decoder and feeds the shared-memory, ALU-out and IR datapath, plus a retired-instruction counter.

---
 rtl/ctrl_pkg.sv | 48 ++++
 rtl/ctrl_out_decode.sv | 101 ++++++++++
 rtl/multicycle_control.sv | 136 +++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, ALU/mux selects and FSM states.
package ctrl_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_ADDI = 4'b0100;
  localparam logic [3:0] OP_BEQ  = 4'b0101;
  localparam logic [3:0] OP_J    = 4'b0110;
  localparam logic [3:0] OP_LW   = 4'b0111;
  localparam logic [3:0] OP_SW   = 4'b1000;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  localparam logic [1:0] ALUB_RT   = 2'b00;
  localparam logic [1:0] ALUB_INC  = 2'b01;
  localparam logic [1:0] ALUB_IMM  = 2'b10;
  localparam logic [1:0] ALUB_BOFF = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StWbAlu,
    StMemAddr,
    StMemRd,
    StWbMem,
    StMemWr,
    StBranch,
    StJump,
    StHalt
  } state_e;

  // R-type opcodes carry the ALU function in their low two bits.
  function automatic logic is_rtype(input logic [3:0] op);
    return op <= OP_OR;
  endfunction

endpackage

// File: rtl/ctrl_out_decode.sv
// Combinational Moore decode of FSM state (plus op_q and mem_ready) into datapath controls.
module ctrl_out_decode
  import ctrl_pkg::*;
(
  input  state_e     i_state,
  input  logic [3:0] i_op,
  input  logic       i_mem_ready,
  output logic       o_pc_write,
  output logic       o_pc_write_cond,
  output logic       o_ir_write,
  output logic       o_i_or_d,
  output logic       o_mem_read,
  output logic       o_mem_write,
  output logic       o_mem_to_reg,
  output logic       o_reg_dst,
  output logic       o_reg_write,
  output logic       o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [1:0] o_alu_op,
  output logic [1:0] o_pc_source,
  output logic       o_instr_done
);

  always_comb begin
    o_pc_write      = 1'b0;
    o_pc_write_cond = 1'b0;
    o_ir_write      = 1'b0;
    o_i_or_d        = 1'b0;
    o_mem_read      = 1'b0;
    o_mem_write     = 1'b0;
    o_mem_to_reg    = 1'b0;
    o_reg_dst       = 1'b0;
    o_reg_write     = 1'b0;
    o_alu_src_a     = 1'b0;
    o_alu_src_b     = ALUB_RT;
    o_alu_op        = ALU_ADD;
    o_pc_source     = PCSRC_ALU;
    o_instr_done    = 1'b0;

    case (i_state)
      StFetch: begin
        o_mem_read  = 1'b1;
        o_alu_src_b = ALUB_INC;
        // PC and IR only commit once the instruction word is actually there.
        o_ir_write  = i_mem_ready;
        o_pc_write  = i_mem_ready;
      end
      StDecode: begin
        o_alu_src_b = ALUB_BOFF;
      end
      StExec: begin
        o_alu_src_a = 1'b1;
        if (is_rtype(i_op)) begin
          o_alu_src_b = ALUB_RT;
          o_alu_op    = i_op[1:0];
        end else begin
          o_alu_src_b = ALUB_IMM;
          o_alu_op    = ALU_ADD;
        end
      end
      StWbAlu: begin
        o_reg_write  = 1'b1;
        o_reg_dst    = is_rtype(i_op);
        o_instr_done = 1'b1;
      end
      StMemAddr: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = ALUB_IMM;
      end
      StMemRd: begin
        o_mem_read = 1'b1;
        o_i_or_d   = 1'b1;
      end
      StWbMem: begin
        o_reg_write  = 1'b1;
        o_mem_to_reg = 1'b1;
        o_instr_done = 1'b1;
      end
      StMemWr: begin
        o_mem_write  = 1'b1;
        o_i_or_d     = 1'b1;
        o_instr_done = i_mem_ready;
      end
      StBranch: begin
        o_alu_src_a     = 1'b1;
        o_alu_src_b     = ALUB_RT;
        o_alu_op        = ALU_SUB;
        o_pc_write_cond = 1'b1;
        o_pc_source     = PCSRC_ALUOUT;
        o_instr_done    = 1'b1;
      end
      StJump: begin
        o_pc_write   = 1'b1;
        o_pc_source  = PCSRC_JUMP;
        o_instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle CPU control FSM with opcode latch and retired-instruction counter.
// Define CTRL_ILLEGAL_TRAP_EN to trap illegal opcodes into HALT with a sticky illegal_op flag.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W = 4,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                ir_write,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                mem_to_reg,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic [1:0]          pc_source,
  output logic                instr_done,
  output logic [CNT_W-1:0]    retired
`ifdef CTRL_ILLEGAL_TRAP_EN
  ,
  output logic                illegal_op
`endif
);

  state_e           r_state;
  state_e           w_state_d;
  logic [3:0]       r_op;
  logic [CNT_W-1:0] r_retired;
  logic             w_illegal;
  logic [3:0]       w_op_lo;
  logic             w_instr_done;

  // Anything above OP_SW (including nonzero upper bits on wide opcodes) is illegal.
  assign w_illegal = (opcode > OPCODE_W'(OP_SW));
  assign w_op_lo   = opcode[3:0];

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:    w_state_d = StFetch;
      StFetch:   w_state_d = mem_ready ? StDecode : StFetch;
      StDecode: begin
        if (w_illegal) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          w_state_d = StHalt;
`else
          w_state_d = StFetch;
`endif
        end else if (w_op_lo <= OP_ADDI) begin
          w_state_d = StExec;
        end else if (w_op_lo == OP_BEQ) begin
          w_state_d = StBranch;
        end else if (w_op_lo == OP_J) begin
          w_state_d = StJump;
        end else begin
          w_state_d = StMemAddr;
        end
      end
      StExec:    w_state_d = StWbAlu;
      StWbAlu:   w_state_d = StFetch;
      StMemAddr: w_state_d = (r_op == OP_LW) ? StMemRd : StMemWr;
      StMemRd:   w_state_d = mem_ready ? StWbMem : StMemRd;
      StWbMem:   w_state_d = StFetch;
      StMemWr:   w_state_d = mem_ready ? StFetch : StMemWr;
      StBranch:  w_state_d = StFetch;
      StJump:    w_state_d = StFetch;
`ifdef CTRL_ILLEGAL_TRAP_EN
      StHalt:    w_state_d = StHalt;
`endif
      default:   w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_op      <= OP_ADD;
      r_retired <= '0;
    end else begin
      r_state <= w_state_d;
      if (r_state == StDecode) begin
        r_op <= w_op_lo;
      end
      if (w_instr_done) begin
        r_retired <= r_retired + CNT_W'(1);
      end
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic r_illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_illegal <= 1'b0;
    end else if (r_state == StDecode && w_illegal) begin
      r_illegal <= 1'b1;
    end
  end

  assign illegal_op = r_illegal;
`endif

  ctrl_out_decode u_out_decode (
    .i_state         (r_state),
    .i_op            (r_op),
    .i_mem_ready     (mem_ready),
    .o_pc_write      (pc_write),
    .o_pc_write_cond (pc_write_cond),
    .o_ir_write      (ir_write),
    .o_i_or_d        (i_or_d),
    .o_mem_read      (mem_read),
    .o_mem_write     (mem_write),
    .o_mem_to_reg    (mem_to_reg),
    .o_reg_dst       (reg_dst),
    .o_reg_write     (reg_write),
    .o_alu_src_a     (alu_src_a),
    .o_alu_src_b     (alu_src_b),
    .o_alu_op        (alu_op),
    .o_pc_source     (pc_source),
    .o_instr_done    (w_instr_done)
  );

  assign instr_done = w_instr_done;
  assign retired    = r_retired;

endmodule
